// File: rtl/frogger_game_fsm_pkg.sv
// Shared constants for the Frogger game-flow controller: state encodings
// and default lives/levels/pause lengths.
package frogger_game_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_DYING     = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  localparam int C_DEF_NB_LIVES       = 3;
  localparam int C_DEF_NB_LEVELS      = 8;
  localparam int C_DEF_DEATH_FRAMES   = 60;
  localparam int C_DEF_LEVELUP_FRAMES = 30;

endpackage

// File: rtl/frogger_game_fsm_frame_timer.sv
// Down-counter of VGA frame ticks. Load wins over a coincident tick, so the
// tick in the load cycle is never counted; o_Done fires on the last tick.
module frogger_game_fsm_frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Clear,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Load_Val,
  input  logic             i_Frame_Tick,
  output logic             o_Done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || i_Clear) begin
      cnt_q <= '0;
    end else if (i_Load) begin
      cnt_q <= i_Load_Val;
    end else if (i_Frame_Tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign o_Done = i_Frame_Tick && !i_Load && !i_Clear && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/frogger_game_fsm.sv
// Frogger game-flow controller: lives, levels, frame-timed death and
// level-up pauses, game over. All outputs are registered.
module frogger_game_fsm
  import frogger_game_fsm_pkg::*;
#(
  parameter int C_NB_LIVES       = C_DEF_NB_LIVES,
  parameter int C_NB_LEVELS      = C_DEF_NB_LEVELS,
  parameter int C_DEATH_FRAMES   = C_DEF_DEATH_FRAMES,
  parameter int C_LEVELUP_FRAMES = C_DEF_LEVELUP_FRAMES,
  parameter int LIVES_W          = $clog2(C_NB_LIVES + 1),
  parameter int LEVEL_W          = $clog2(C_NB_LEVELS)
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Frame_Tick,
  input  logic               i_Start,
  input  logic               i_Has_Collided,
  input  logic               i_Reached_Goal,
  output logic [2:0]         o_State,
  output logic               o_Game_Active,
  output logic [LIVES_W-1:0] o_Lives,
  output logic [LEVEL_W-1:0] o_Level,
  output logic               o_Respawn,
  output logic               o_Level_Up,
  output logic               o_Game_Over
);

  localparam int C_MAX_PAUSE = (C_DEATH_FRAMES > C_LEVELUP_FRAMES) ?
                               C_DEATH_FRAMES : C_LEVELUP_FRAMES;
  localparam int CNT_W = $clog2(C_MAX_PAUSE + 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(C_NB_LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(C_NB_LEVELS - 1);

  state_e             state_q;
  logic [LIVES_W-1:0] lives_q;
  logic [LEVEL_W-1:0] level_q;
  logic               start_prev_q;
  logic               respawn_q;
  logic               level_up_q;
  logic               game_active_q;
  logic               game_over_q;
  logic               load_q;

  logic               start_edge;
  logic               timer_clear;
  logic               timer_done;
  logic [CNT_W-1:0]   timer_load_val;

  assign start_edge     = i_Start && !start_prev_q;
  assign timer_clear    = (state_q != ST_DYING) && (state_q != ST_LEVEL_UP);
  assign timer_load_val = (state_q == ST_DYING) ? CNT_W'(C_DEATH_FRAMES)
                                                : CNT_W'(C_LEVELUP_FRAMES);

  // load_q is high during the first cycle of a pause, which is what keeps
  // a tick in that entry cycle out of the count.
  frogger_game_fsm_frame_timer #(
    .CNT_W(CNT_W)
  ) u_frame_timer (
    .i_Clk       (i_Clk),
    .i_Rst_n     (i_Rst_n),
    .i_Clear     (timer_clear),
    .i_Load      (load_q),
    .i_Load_Val  (timer_load_val),
    .i_Frame_Tick(i_Frame_Tick),
    .o_Done      (timer_done)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q       <= ST_IDLE;
      lives_q       <= '0;
      level_q       <= '0;
      start_prev_q  <= 1'b1;
      respawn_q     <= 1'b0;
      level_up_q    <= 1'b0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      load_q        <= 1'b0;
    end else begin
      start_prev_q <= i_Start;
      respawn_q    <= 1'b0;
      level_up_q   <= 1'b0;
      load_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q       <= ST_RUNNING;
            lives_q       <= LIVES_INIT;
            level_q       <= '0;
            respawn_q     <= 1'b1;
            game_active_q <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (i_Has_Collided) begin
            state_q       <= ST_DYING;
            lives_q       <= lives_q - LIVES_W'(1);
            load_q        <= 1'b1;
            game_active_q <= 1'b0;
          end else if (i_Reached_Goal) begin
            state_q       <= ST_LEVEL_UP;
            level_up_q    <= 1'b1;
            load_q        <= 1'b1;
            game_active_q <= 1'b0;
            if (level_q != LEVEL_TOP) begin
              level_q <= level_q + LEVEL_W'(1);
            end
          end
        end
        ST_DYING: begin
          if (timer_done) begin
            if (lives_q == '0) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q       <= ST_RUNNING;
              respawn_q     <= 1'b1;
              game_active_q <= 1'b1;
            end
          end
        end
        ST_LEVEL_UP: begin
          if (timer_done) begin
            state_q       <= ST_RUNNING;
            respawn_q     <= 1'b1;
            game_active_q <= 1'b1;
          end
        end
        ST_GAME_OVER: begin
          // Lives and level are left untouched so the display keeps them.
          if (start_edge) begin
            state_q     <= ST_IDLE;
            game_over_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          game_active_q <= 1'b0;
          game_over_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_State       = state_q;
  assign o_Game_Active = game_active_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Respawn     = respawn_q;
  assign o_Level_Up    = level_up_q;
  assign o_Game_Over   = game_over_q;

endmodule

// File: doc/frogger_game_fsm.md
Name: frogger_game_fsm

Overview:
Parametrised game-flow controller replacing the two-state IDLE/RUNNING machine in the Frogger top level. Adds lives, levels, timed death and level-up pauses, and a game-over state. All pause timing is counted in VGA frames. Sits between the collision/character logic and the sprite, obstacle and seven-segment blocks.

Parameters:
C_NB_LIVES, 3, lives granted at game start (1..15)
C_NB_LEVELS, 8, number of levels; level saturates at C_NB_LEVELS-1
C_DEATH_FRAMES, 60, frame ticks spent in DYING
C_LEVELUP_FRAMES, 30, frame ticks spent in LEVEL_UP
LIVES_W, $clog2(C_NB_LIVES+1), derived, lives counter width
LEVEL_W, $clog2(C_NB_LEVELS), derived, level counter width

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  synchronous active-low reset
i_Frame_Tick  in  1  one-cycle pulse per VGA frame
i_Start  in  1  debounced all-switches level
i_Has_Collided  in  1  frog/car collision, level
i_Reached_Goal  in  1  frog reached top row, one-cycle pulse
o_State  out  3  current state encoding
o_Game_Active  out  1  high only in RUNNING
o_Lives  out  LIVES_W  remaining lives
o_Level  out  LEVEL_W  current level, 0-based
o_Respawn  out  1  one-cycle pulse: frog returns to base position
o_Level_Up  out  1  one-cycle pulse on entry to LEVEL_UP
o_Game_Over  out  1  high only in GAME_OVER

Behaviour:
- Interface (already decided): one clock i_Clk; reset i_Rst_n is synchronous and active-low.
- Reset values: state IDLE, o_Lives 0, o_Level 0, all pulses 0, o_Game_Active 0, o_Game_Over 0, frame counter 0. The start-edge register resets to 1, so a switch held through reset does not start a game.
- Start edge: a start edge is i_Start=1 with the previous-cycle i_Start=0.
- Outputs: all outputs are registered. A state change and its outputs are visible one cycle after the triggering input is sampled.
- IDLE:
  - On start edge -> RUNNING.
  - Same edge: o_Lives<=C_NB_LIVES, o_Level<=0, o_Respawn pulses.
- RUNNING:
  - i_Has_Collided=1 -> DYING, o_Lives<=o_Lives-1.
  - Else if i_Reached_Goal=1 -> LEVEL_UP, o_Level_Up pulses, o_Level<=min(o_Level+1, C_NB_LEVELS-1).
  - Collision has priority over goal when both occur in the same cycle.
- DYING:
  - Counts i_Frame_Tick pulses; collision and goal inputs are ignored.
  - When the count reaches C_DEATH_FRAMES: if o_Lives==0 -> GAME_OVER, else -> RUNNING with o_Respawn pulse.
- LEVEL_UP:
  - Counts C_LEVELUP_FRAMES ticks -> RUNNING with o_Respawn pulse. Inputs are ignored.
  - At the top level, o_Level stays at C_NB_LEVELS-1 but the pause and respawn still occur.
- GAME_OVER: o_Game_Over=1; o_Lives and o_Level hold for display. On start edge -> IDLE.
- Frame counter: cleared on every state entry. A tick in the entry cycle is not counted; counting begins the next cycle. Width is $clog2(max pause+1).
- Lives arithmetic: never decremented below 0, since decrement occurs only in RUNNING and lives are ≥1 there.
- Reset mid-operation: in any state or mid-pause, i_Rst_n=0 returns all values to reset state on the next edge; no pulse is emitted.
- State encodings: IDLE=0, RUNNING=1, DYING=2, LEVEL_UP=3, GAME_OVER=4. Encodings 5-7 -> IDLE on the next cycle.

Decomposition:
- Shared package (Constants): state encodings, the C_NB_LIVES/C_NB_LEVELS defaults, and the pause-frame defaults.
- One sub-module: frame_timer.
  - Parametrised down-counter of frame ticks, with clear and load inputs and a one-cycle o_Done output.
  - Instantiated once; loaded with C_DEATH_FRAMES or C_LEVELUP_FRAMES on state entry.

Test Plan:
1. Reset with i_Start held at 1, then release and raise i_Start -> no start during hold. On the rising edge: state RUNNING, o_Lives=3, o_Level=0, o_Respawn high for exactly 1 cycle.
2. In RUNNING, pulse i_Reached_Goal 8 times, each followed by 30 frame ticks -> o_Level goes 1..7 then stays 7. o_Level_Up pulses 8 times; state returns to RUNNING after each 30th tick.
3. In RUNNING, assert i_Has_Collided for 5 cycles -> o_Lives 3->2 once. State DYING; 59 ticks keep DYING; 60th tick -> RUNNING with o_Respawn.
4. Assert i_Has_Collided and i_Reached_Goal in the same cycle -> DYING, o_Lives decremented, o_Level unchanged, no o_Level_Up.
5. Lose 3 lives -> after the 3rd DYING pause state is GAME_OVER, o_Game_Over=1, o_Lives=0. A start edge -> IDLE; a second start edge -> RUNNING with o_Lives=3.
6. Pull i_Rst_n low mid-DYING (tick 20) -> next cycle state IDLE, o_Lives=0, o_Level=0, no o_Respawn pulse.
